// File: rtl/mac_8bit.sv
// mac_8bit: sequential 8-bit unsigned multiply-accumulate.
// Computes product = multiplicand * multiplier + addend with one shift-add step per clock.
// Optional build macro MAC_EARLY_TERM_EN: leave CALC as soon as no multiplier bits remain.
module mac_8bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  input  logic [7:0]  addend,
  output logic [15:0] product,
  output logic        done,
  output logic        idle
);

  // The encoding 2'b01 is never assigned and falls back to IDLE through the default arm.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CALC     = 2'b11,
    POSTCALC = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] mcand_reg;
  logic [15:0] acc;
  logic [7:0]  mult_reg;
  logic [2:0]  step;
  logic        calc_last;

  // Decide whether the current CALC cycle is the final shift-add step.
`ifdef MAC_EARLY_TERM_EN
  always_comb calc_last = (step == 3'd7) || (mult_reg[7:1] == 7'd0);
`else
  always_comb calc_last = (step == 3'd7);
`endif

  // Register the FSM state.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Compute the next state.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:     state_nxt = strt ? CALC : IDLE;
      CALC:     state_nxt = calc_last ? POSTCALC : CALC;
      POSTCALC: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign idle = (state == IDLE);

  // Capture the operands, run the shift-add steps and publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg <= 16'd0;
      mult_reg  <= 8'd0;
      acc       <= 16'd0;
      step      <= 3'd0;
      product   <= 16'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (strt) begin
            mcand_reg <= {8'd0, multiplicand};
            mult_reg  <= multiplier;
            acc       <= {8'd0, addend};
            step      <= 3'd0;
          end
        end
        CALC: begin
          // The result cannot exceed 65280, so the carry-out is always zero and is dropped.
          if (mult_reg[0]) acc <= acc + mcand_reg;
          mcand_reg <= {mcand_reg[14:0], 1'b0};
          mult_reg  <= {1'b0, mult_reg[7:1]};
          step      <= step + 3'd1;
        end
        POSTCALC: begin
          product <= acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_8bit.sv
// tb_mac_8bit: randomized self-checking bench for mac_8bit against an arithmetic reference.
// Build with MAC_EARLY_TERM_EN defined to check the early-termination latency.
module tb_mac_8bit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic [7:0]  addend = '0;
  logic [15:0] product;
  logic        done;
  logic        idle;

  int checks = 0;
  int errors = 0;

  mac_8bit dut (
    .clk(clk), .rst(rst), .strt(strt),
    .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
    .product(product), .done(done), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Clocks from the accepting edge to the edge at which the result becomes visible.
  function automatic int ref_lat(input int b);
`ifdef MAC_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < 8; i++) if ((b >> i) & 1) h = i;
    return 2 + h;
`else
    return 9;
`endif
  endfunction

  // One operation from IDLE; operands are scrambled right after capture.
  task automatic run_op(input int a, input int b, input int c);
    int cnt;
    bit seen;
    @(negedge clk);
    multiplicand = a[7:0]; multiplier = b[7:0]; addend = c[7:0]; strt = 1'b1;
    @(posedge clk); #1;
    strt = 1'b0;
    multiplicand = 8'($urandom); multiplier = 8'($urandom); addend = 8'($urandom);
    seen = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("idle_busy", int'(idle), (ref_lat(b) == 1) ? 1 : 0);
      if (done) begin seen = 1'b1; cnt = k; break; end
    end
    chk("timeout", int'(seen), 1);
    if (seen) begin
      chk("product", int'(product), a * b + c);
      chk("latency", cnt, ref_lat(b));
      chk("idle_after", int'(idle), 1);
      @(posedge clk); #1;
      chk("done_pulse", int'(done), 0);
      chk("product_hold", int'(product), a * b + c);
    end
  endtask

  int dirs [6][3] = '{'{13, 11, 7}, '{255, 255, 255}, '{0, 200, 9},
                      '{7, 28, 3}, '{50, 1, 5}, '{2, 128, 0}};

  localparam int N = 64;
  int ra [N]; int rb [N]; int rc [N];
  int done_cyc [$];
  int done_val [$];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_product", int'(product), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idle", int'(idle), 1);
    @(negedge clk) rst = 1'b0;

    foreach (dirs[i]) run_op(dirs[i][0], dirs[i][1], dirs[i][2]);
    run_op(77, 0, 4);

    // Divider round-trip style sweep: A >= 1, C < A.
    for (int i = 0; i < 25; i++) begin
      int a, b, c;
      a = $urandom_range(255, 1);
      b = $urandom_range(255, 0);
      c = $urandom_range(a - 1, 0);
      run_op(a, b, c);
    end

    // Reset during the 4th CALC cycle discards the operation.
    @(negedge clk);
    multiplicand = 8'd100; multiplier = 8'd100; addend = 8'd0; strt = 1'b1;
    @(posedge clk); #1;
    strt = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_product", int'(product), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_idle", int'(idle), 1);
    rst = 1'b0;
    begin
      int stray;
      stray = 0;
      repeat (12) begin @(posedge clk); #1; if (done) stray++; end
      chk("midrst_no_done", stray, 0);
    end
    run_op(2, 3, 1);

    // strt held high with operands changing every cycle.
    for (int cyc = 0; cyc < N; cyc++) begin
      @(negedge clk);
      ra[cyc] = $urandom_range(255, 0);
      rb[cyc] = $urandom_range(255, 0);
      rc[cyc] = $urandom_range(255, 0);
      multiplicand = ra[cyc][7:0]; multiplier = rb[cyc][7:0]; addend = rc[cyc][7:0];
      strt = 1'b1;
      @(posedge clk); #1;
      if (done) begin done_cyc.push_back(cyc); done_val.push_back(int'(product)); end
    end
    @(negedge clk) strt = 1'b0;
    begin
      int t, n;
      t = 0; n = 0;
      while (t + ref_lat(rb[t]) < N) begin
        if (n < done_cyc.size()) begin
          chk("b2b_cycle", done_cyc[n], t + ref_lat(rb[t]));
          chk("b2b_product", done_val[n], ra[t] * rb[t] + rc[t]);
        end
        n++;
        t = t + ref_lat(rb[t]) + 1;
      end
      chk("b2b_count", done_cyc.size(), n);
    end
    repeat (12) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_8bit.md
# mac_8bit

Sequential 8-bit unsigned multiply-accumulate computing product = multiplicand × multiplier + addend, one shift-add step per clock. It is the inverse companion of the team's sequential 8-bit divider: feeding it (divisor, quotient, remainder) rebuilds the dividend. It is used for divider self-check and wherever a small, slow, area-cheap multiplier is enough.

## Interface
- No parameters; widths fixed at 8-bit operands, 16-bit result.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- strt  input  1  start request; sampled only in IDLE.
- multiplicand  input  8  unsigned operand A; captured on accepted strt.
- multiplier  input  8  unsigned operand B; captured on accepted strt.
- addend  input  8  unsigned operand C, zero-extended; captured on accepted strt.
- product  output  16  registered A×B+C; holds last result until next POSTCALC.
- done  output  1  registered one-cycle pulse, high in the cycle product first shows a new result.
- idle  output  1  combinational, high when state is IDLE.

## Operation
- States (2-bit): IDLE=00, CALC=11, POSTCALC=10; 01 unused, decodes to IDLE next cycle.
- Internal: mcand_reg[15:0], mult_reg[7:0], acc[15:0], step[2:0].
- IDLE: if strt, load mcand_reg<={8'b0,A}, mult_reg<=B, acc<={8'b0,C}, step<=0, go CALC. Otherwise hold.
- CALC, each cycle: if mult_reg[0], acc<=acc+mcand_reg (16-bit, no carry-out). Then mcand_reg<<=1, mult_reg>>=1, step<=step+1. Leave for POSTCALC when step==7; else stay.
- POSTCALC: product<=acc, done<=1, go IDLE.
- done is 0 in every cycle except the one following POSTCALC.
- Width rule: max result 255×255+255=65280 < 2^16, so no overflow is possible and no flag is provided.
- strt outside IDLE is ignored. Operand changes after capture have no effect on the running operation.
- strt held high continuously: a new operation is accepted on the first IDLE cycle after each result.
- Reset (any state, including mid-CALC): state<=IDLE, product<=0, done<=0, internal registers<=0; operation discarded.

## Timing
- Reset values: product=0, done=0, idle=1.
- Edge 0: strt sampled high in IDLE -> CALC.
- Edges 1..8: eight CALC iterations (fixed build). At edge 8 step==7 -> POSTCALC.
- Edge 9: product and done update; idle goes high. Latency = 9 clocks from the accepting edge to result visibility.
- Back-to-back throughput: one result per 10 clocks.
- idle is low from after edge 0 through edge 9.

## Configuration
- Macro MAC_EARLY_TERM_EN.
- Defined: CALC also exits to POSTCALC when mult_reg[7:1]==0 in the current CALC cycle, because no set bits remain. Number of CALC cycles = 1 + index of the highest set bit of B; B=0 or B=1 gives one CALC cycle. Latency = 2 + that index, ranging 2..9. Results are identical to the fixed build.
- Undefined: always exactly 8 CALC cycles; latency fixed at 9.

## Test plan
- Reset, then A=13, B=11, C=7, strt one cycle -> product=150 (0x0096), done pulse 9 clocks after the accepting edge (fixed build), idle back high.
- A=255, B=255, C=255 -> product=65280 (0xFF00); a following A=0, B=200, C=9 -> product=9.
- Divider round-trip: A=7, B=28, C=3 -> product=199; repeat with a random sweep of A≥1, B, C<A, checked against a reference model.
- Assert rst at the 4th CALC cycle of A=100, B=100, C=0 -> next cycle product=0, done=0, idle=1. Then A=2, B=3, C=1 -> product=7.
- Hold strt high with operands changing every cycle -> each result matches the operands present on its accepting edge. Results arrive every 10 clocks. Operand changes mid-operation are ignored.
- With MAC_EARLY_TERM_EN: B=1, A=50, C=5 -> product=55 after 2 clocks; B=0x80, A=2, C=0 -> product=256 after 9 clocks; B=0, A=77, C=4 -> product=4 after 2 clocks.
